// File: rtl/counter_delta_batcher.sv
// counter_delta_batcher: batches per-lane inc/dec events into 0..3 deltas per cycle for the up/down counter and sequences reinit after draining.
// Optional NET_CANCEL_EN: matched inc/dec events cancel before emission.
module counter_delta_batcher #(
    parameter int LANES  = 4,
    parameter int ACC_W  = 4,
    parameter int INIT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LANES-1:0]  inc_evt,
    input  logic [LANES-1:0]  dec_evt,
    output logic              inc_ready,
    output logic              dec_ready,
    input  logic              reinit_req,
    input  logic [INIT_W-1:0] init_val,
    output logic              reinit_ack,
    output logic              incr_valid,
    output logic [1:0]        incr,
    output logic              decr_valid,
    output logic [1:0]        decr,
    output logic              reinit,
    output logic [INIT_W-1:0] initial_value,
    output logic              overflow,
    output logic              busy
);
    localparam int CW = ACC_W + 1;
    localparam logic [CW-1:0] LIMIT = CW'((1 << ACC_W) - 1 - LANES);

    typedef enum logic [1:0] {IDLE, DRAIN, REINIT} state_t;

    state_t              r_state, w_next;
    logic [ACC_W-1:0]    r_inc_acc, r_dec_acc;
    logic [INIT_W-1:0]   r_init_cap, r_initial;
    logic                r_incr_valid, r_decr_valid, r_reinit, r_overflow;
    logic [1:0]          r_incr, r_decr;
    logic [CW-1:0]       w_inc_total, w_dec_total, w_inc_net, w_dec_net;
    logic [1:0]          w_inc_emit, w_dec_emit;
    logic [ACC_W-1:0]    w_inc_rem, w_dec_rem;
    logic                w_ovf_set;

    function automatic logic [CW-1:0] popcnt(input logic [LANES-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++)
            n = n + CW'(v[i]);
        return n;
    endfunction

    assign inc_ready = (r_state == IDLE) && ({1'b0, r_inc_acc} <= LIMIT);
    assign dec_ready = (r_state == IDLE) && ({1'b0, r_dec_acc} <= LIMIT);

    assign w_inc_total = {1'b0, r_inc_acc} + (inc_ready ? popcnt(inc_evt) : '0);
    assign w_dec_total = {1'b0, r_dec_acc} + (dec_ready ? popcnt(dec_evt) : '0);

`ifdef NET_CANCEL_EN
    // Readies are low and accumulators empty in REINIT, so cancelling there is a no-op.
    logic [CW-1:0] w_match;
    assign w_match   = (w_inc_total < w_dec_total) ? w_inc_total : w_dec_total;
    assign w_inc_net = w_inc_total - w_match;
    assign w_dec_net = w_dec_total - w_match;
`else
    assign w_inc_net = w_inc_total;
    assign w_dec_net = w_dec_total;
`endif

    assign w_inc_emit = (w_inc_net > CW'(3)) ? 2'd3 : w_inc_net[1:0];
    assign w_dec_emit = (w_dec_net > CW'(3)) ? 2'd3 : w_dec_net[1:0];
    assign w_inc_rem  = ACC_W'(w_inc_net - CW'(w_inc_emit));
    assign w_dec_rem  = ACC_W'(w_dec_net - CW'(w_dec_emit));
    assign w_ovf_set  = (|inc_evt && !inc_ready) || (|dec_evt && !dec_ready);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = reinit_req ? DRAIN : IDLE;
            DRAIN:   w_next = (r_inc_acc == '0 && r_dec_acc == '0) ? REINIT : DRAIN;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_inc_acc    <= '0;
            r_dec_acc    <= '0;
            r_init_cap   <= '0;
            r_initial    <= '0;
            r_incr_valid <= 1'b0;
            r_decr_valid <= 1'b0;
            r_incr       <= 2'd0;
            r_decr       <= 2'd0;
            r_reinit     <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_inc_acc    <= w_inc_rem;
            r_dec_acc    <= w_dec_rem;
            if (r_state == IDLE && reinit_req)
                r_init_cap <= init_val;
            r_incr       <= w_inc_emit;
            r_decr       <= w_dec_emit;
            r_incr_valid <= w_inc_emit != 2'd0;
            r_decr_valid <= w_dec_emit != 2'd0;
            // Entering REINIT implies both accumulators are empty, so no delta shares the reinit cycle.
            r_reinit     <= w_next == REINIT;
            r_initial    <= (w_next == REINIT) ? r_init_cap : '0;
            r_overflow   <= w_ovf_set || (r_overflow && w_next != REINIT);
        end
    end

    assign incr_valid    = r_incr_valid;
    assign incr          = r_incr;
    assign decr_valid    = r_decr_valid;
    assign decr          = r_decr;
    assign reinit        = r_reinit;
    assign reinit_ack    = r_reinit;
    assign initial_value = r_initial;
    assign overflow      = r_overflow;
    assign busy          = (r_state != IDLE) || (r_inc_acc != '0) || (r_dec_acc != '0);
endmodule
